// File: rtl/game_pkg.sv
// Shared game definitions: state encoding, coordinate widths, LFSR seed/taps
// and the BCD digit type used by the score and HEX decoders.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_OVER = 2'b10
  } game_state_t;

  localparam int X_W    = 10;
  localparam int Y_W    = 11;
  localparam int LFSR_W = 9;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 9'h1A5;
  // Feedback taps: bits 8, 6, 5, 4
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 9'h170;

  typedef logic [3:0] bcd_t;

  // One LFSR step; an all-zero state is treated as a lockup and reloads the seed.
  function automatic logic [LFSR_W-1:0] lfsr_adv(input logic [LFSR_W-1:0] d,
                                                 input logic [LFSR_W-1:0] seed);
    logic [LFSR_W-1:0] r;
    if (d == '0) r = seed;
    else         r = {d[LFSR_W-2:0], ^(d & LFSR_TAPS)};
    return r;
  endfunction

endpackage

// File: rtl/asteroid_scheduler_spawn_lfsr.sv
// Spawn-position LFSR: advances 0..MAX_STEPS times per cycle, with zero-state guard.
module spawn_lfsr #(
  parameter int          MAX_STEPS = 8,
  parameter int          STEP_W    = 4,
  parameter logic [8:0]  SEED      = game_pkg::LFSR_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [STEP_W-1:0] step,
  output logic [8:0]        value
);
  import game_pkg::*;

  logic [8:0] nxt;

  always_comb begin
    nxt = value;
    for (int unsigned i = 0; i < MAX_STEPS; i++) begin
      if (i < 32'(step)) nxt = lfsr_adv(nxt, SEED);
    end
    if (nxt == '0) nxt = SEED;
  end

  always_ff @(posedge clk) begin
    if (reset) value <= SEED;
    else       value <= nxt;
  end

endmodule

// File: rtl/asteroid_scheduler.sv
// Game-flow controller and asteroid slot scheduler (IDLE/PLAY/OVER, hits, BCD score).
// Optional ASTEROID_SPEEDUP_EN: movement step grows with the score tens digit.
module asteroid_scheduler #(
  parameter int          NUM_AST   = 4,
  parameter int          AST_SIZE  = 25,
  parameter int          SPAWN_Y   = -25,
  parameter int          SPAWN_GAP = 50,
  parameter int          Y_LIMIT   = 450,
  parameter int          X_OFFSET  = 40,
  parameter logic [8:0]  LFSR_SEED = 9'h1A5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  hit_valid,
  input  logic [NUM_AST-1:0]    hit_mask,
  output logic                  hit_ack,
  output logic [2:0]            hit_idx,
  output logic [NUM_AST-1:0]    ast_active,
  output logic [NUM_AST*10-1:0] ast_x,
  output logic [NUM_AST*11-1:0] ast_y,
  output logic [3:0]            score_ones,
  output logic [3:0]            score_tens,
  output logic [1:0]            state,
  output logic                  game_over
);
  import game_pkg::*;

  localparam int STEP_W = 4;
  localparam logic signed [Y_W-1:0] SPAWN_Y_V = Y_W'(SPAWN_Y);
  localparam logic signed [Y_W-1:0] Y_LIM_V   = Y_W'(Y_LIMIT);
  localparam logic [X_W-1:0]        X_OFF_V   = X_W'(X_OFFSET);
  localparam logic [X_W-1:0]        X_MAX_V   = X_W'(640 - AST_SIZE - 1);

  game_state_t               st_q;
  logic [NUM_AST-1:0]        active_q;
  logic [X_W-1:0]            x_q   [NUM_AST];
  logic signed [Y_W-1:0]     y_q   [NUM_AST];
  bcd_t                      ones_q, tens_q;
  logic                      ack_q, over_q;
  logic [2:0]                idx_q;

  logic [LFSR_W-1:0]         lfsr_q;
  logic [LFSR_W-1:0]         ahead [NUM_AST];
  logic [X_W-1:0]            spawn_x [NUM_AST];
  logic [STEP_W-1:0]         lfsr_step;

  logic [NUM_AST-1:0]        eff;
  logic                      hit_win;
  logic [2:0]                hit_k;
  logic signed [Y_W-1:0]     y_step;
  logic signed [Y_W-1:0]     y_upd [NUM_AST];
  logic                      escape;
  logic                      do_init;

  spawn_lfsr #(
    .MAX_STEPS (NUM_AST),
    .STEP_W    (STEP_W),
    .SEED      (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (lfsr_step),
    .value (lfsr_q)
  );

  // ahead[i] is the LFSR value after i+1 steps; slot i of an init takes ahead[i].
  always_comb begin
    ahead[0] = lfsr_adv(lfsr_q, LFSR_SEED);
    for (int unsigned i = 1; i < NUM_AST; i++) ahead[i] = lfsr_adv(ahead[i-1], LFSR_SEED);
    for (int unsigned i = 0; i < NUM_AST; i++) begin
      spawn_x[i] = X_OFF_V + X_W'(ahead[i]);
      if (spawn_x[i] > X_MAX_V) spawn_x[i] = X_MAX_V;
    end
  end

  always_comb begin
    eff     = (st_q == ST_PLAY && hit_valid) ? (hit_mask & active_q) : '0;
    hit_win = 1'b0;
    hit_k   = '0;
    for (int unsigned i = 0; i < NUM_AST; i++) begin
      if (eff[i] && !hit_win) begin
        hit_win = 1'b1;
        hit_k   = 3'(i);
      end
    end
  end

  always_comb begin
`ifdef ASTEROID_SPEEDUP_EN
    y_step = (tens_q >= 4'd3) ? Y_W'(4) : Y_W'(tens_q) + Y_W'(1);
`else
    y_step = Y_W'(1);
`endif
    escape = 1'b0;
    for (int unsigned i = 0; i < NUM_AST; i++) begin
      y_upd[i] = tick ? y_q[i] + y_step : y_q[i];
      if (active_q[i] && !(hit_win && hit_k == 3'(i)) && y_upd[i] >= Y_LIM_V) escape = 1'b1;
    end
  end

  always_comb begin
    do_init   = (st_q != ST_PLAY) && start;
    lfsr_step = '0;
    if (do_init)      lfsr_step = STEP_W'(NUM_AST);
    else if (hit_win) lfsr_step = STEP_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q     <= ST_IDLE;
      active_q <= '0;
      for (int unsigned i = 0; i < NUM_AST; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
      ones_q <= '0;
      tens_q <= '0;
      ack_q  <= 1'b0;
      idx_q  <= '0;
      over_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (st_q)
        ST_PLAY: begin
          if (hit_win) begin
            ack_q <= 1'b1;
            idx_q <= hit_k;
            if (ones_q == 4'd9) begin
              if (tens_q != 4'd9) begin
                ones_q <= '0;
                tens_q <= tens_q + 4'd1;
              end
            end else begin
              ones_q <= ones_q + 4'd1;
            end
          end
          // A hit slot respawns instead of moving, which also cancels its escape.
          for (int unsigned i = 0; i < NUM_AST; i++) begin
            if (hit_win && hit_k == 3'(i)) begin
              y_q[i] <= SPAWN_Y_V;
              x_q[i] <= spawn_x[0];
            end else if (active_q[i]) begin
              y_q[i] <= y_upd[i];
            end
          end
          if (escape) begin
            st_q   <= ST_OVER;
            over_q <= 1'b1;
          end
        end
        default: begin
          if (do_init) begin
            st_q     <= ST_PLAY;
            over_q   <= 1'b0;
            active_q <= '1;
            ones_q   <= '0;
            tens_q   <= '0;
            for (int unsigned i = 0; i < NUM_AST; i++) begin
              y_q[i] <= Y_W'(SPAWN_Y - SPAWN_GAP * int'(i));
              x_q[i] <= spawn_x[i];
            end
          end
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_AST; g++) begin : g_pack
    assign ast_x[g*X_W +: X_W] = x_q[g];
    assign ast_y[g*Y_W +: Y_W] = y_q[g];
  end

  assign ast_active = active_q;
  assign score_ones = ones_q;
  assign score_tens = tens_q;
  assign hit_ack    = ack_q;
  assign hit_idx    = idx_q;
  assign state      = st_q;
  assign game_over  = over_q;

endmodule

// File: tb/tb_asteroid_scheduler.sv
// Randomized bench for asteroid_scheduler against an integer-level game model.
module tb_asteroid_scheduler;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset, tick, start, hit_valid;
  logic [N-1:0]    hit_mask;
  logic            hit_ack;
  logic [2:0]      hit_idx;
  logic [N-1:0]    ast_active;
  logic [N*10-1:0] ast_x;
  logic [N*11-1:0] ast_y;
  logic [3:0]      score_ones, score_tens;
  logic [1:0]      state;
  logic            game_over;

  int tests = 0;
  int fails = 0;

  // Model state, plain integers
  int m_state, m_lfsr, m_score, m_ack, m_idx, m_over;
  int m_active [N];
  int m_x [N];
  int m_y [N];

  asteroid_scheduler #(
    .NUM_AST   (N),
    .AST_SIZE  (25),
    .SPAWN_Y   (-25),
    .SPAWN_GAP (50),
    .Y_LIMIT   (450),
    .X_OFFSET  (40),
    .LFSR_SEED (9'h1A5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .start      (start),
    .hit_valid  (hit_valid),
    .hit_mask   (hit_mask),
    .hit_ack    (hit_ack),
    .hit_idx    (hit_idx),
    .ast_active (ast_active),
    .ast_x      (ast_x),
    .ast_y      (ast_y),
    .score_ones (score_ones),
    .score_tens (score_tens),
    .state      (state),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  function automatic int lfsr_model(input int d);
    int fb;
    if (d == 0) return 'h1A5;
    fb = ((d >> 8) ^ (d >> 6) ^ (d >> 5) ^ (d >> 4)) & 1;
    return ((d << 1) & 'h1FF) | fb;
  endfunction

  function automatic int dut_x(input int i);
    logic [9:0] v;
    v = ast_x[i*10 +: 10];
    return int'(v);
  endfunction

  function automatic int dut_y(input int i);
    logic signed [10:0] v;
    v = ast_y[i*11 +: 11];
    return int'(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int k, stepv;
    if (reset) begin
      m_state = 0; m_lfsr = 'h1A5; m_score = 0; m_ack = 0; m_idx = 0; m_over = 0;
      for (int i = 0; i < N; i++) begin m_active[i] = 0; m_x[i] = 0; m_y[i] = 0; end
    end else if (m_state != 1) begin
      m_ack = 0;
      if (start) begin
        for (int i = 0; i < N; i++) begin
          m_lfsr = lfsr_model(m_lfsr);
          m_active[i] = 1;
          m_x[i] = 40 + m_lfsr;
          m_y[i] = -25 - 50 * i;
        end
        m_score = 0; m_state = 1; m_over = 0;
      end
    end else begin
      m_ack = 0;
      k = -1;
`ifdef ASTEROID_SPEEDUP_EN
      stepv = (m_score / 10 + 1 > 4) ? 4 : m_score / 10 + 1;
`else
      stepv = 1;
`endif
      if (hit_valid)
        for (int i = 0; i < N; i++)
          if (k < 0 && hit_mask[i] && m_active[i] != 0) k = i;
      if (k >= 0) begin
        m_lfsr = lfsr_model(m_lfsr);
        m_x[k] = 40 + m_lfsr;
        m_y[k] = -25;
        m_ack = 1; m_idx = k;
        if (m_score < 99) m_score++;
      end
      for (int i = 0; i < N; i++)
        if (i != k && m_active[i] != 0 && tick) m_y[i] += stepv;
      for (int i = 0; i < N; i++)
        if (i != k && m_active[i] != 0 && m_y[i] >= 450) begin m_state = 2; m_over = 1; end
    end
  endtask

  task automatic compare_all();
    chk("state", int'(state), m_state);
    chk("game_over", int'(game_over), m_over);
    chk("hit_ack", int'(hit_ack), m_ack);
    chk("hit_idx", int'(hit_idx), m_idx);
    chk("score_ones", int'(score_ones), m_score % 10);
    chk("score_tens", int'(score_tens), m_score / 10);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("active%0d", i), int'(ast_active[i]), m_active[i]);
      chk($sformatf("x%0d", i), dut_x(i), m_x[i]);
      chk($sformatf("y%0d", i), dut_y(i), m_y[i]);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_in();
    reset = 0; tick = 0; start = 0; hit_valid = 0; hit_mask = '0;
  endtask

  initial begin
    idle_in();
    reset = 1;
    cyc(); cyc();
    chk("rst_state", int'(state), 0);
    chk("rst_active", int'(ast_active), 0);
    chk("rst_score", int'({score_tens, score_ones}), 0);

    idle_in(); start = 1; cyc();
    start = 0;
    chk("init_state", int'(state), 1);
    chk("init_y0", dut_y(0), -25);
    chk("init_y3", dut_y(3), -175);
    chk("init_x0", dut_x(0), 370);
    chk("init_x1", dut_x(1), 188);
    chk("init_active", int'(ast_active), 15);

    tick = 1;
    repeat (25) cyc();
    tick = 0;
    chk("t25_y0", dut_y(0), 0);
    chk("t25_y3", dut_y(3), -150);
    chk("t25_ack", int'(hit_ack), 0);

    hit_valid = 1; hit_mask = 4'b0110; cyc();
    chk("hit_ack", int'(hit_ack), 1);
    chk("hit_idx1", int'(hit_idx), 1);
    chk("hit_y1", dut_y(1), -25);
    chk("hit_x1_range", int'(dut_x(1) >= 40 && dut_x(1) <= 551), 1);
    chk("hit_y2", dut_y(2), -100);
    chk("hit_score", int'(score_ones), 1);

    tick = 1; hit_mask = 4'b0001; cyc();
    chk("tickhit_y0", dut_y(0), -25);
    chk("tickhit_y1", dut_y(1), -24);
    chk("tickhit_y2", dut_y(2), -99);
    idle_in();

    for (int c = 0; c < 600; c++) begin
      tick      = $urandom_range(0, 1) == 1;
      hit_valid = $urandom_range(0, 3) == 0;
      hit_mask  = 4'($urandom);
      start     = $urandom_range(0, 29) == 0;
      reset     = $urandom_range(0, 199) == 0;
      cyc();
    end
    idle_in();

    reset = 1; cyc();
    idle_in(); start = 1; cyc();
    start = 0; hit_valid = 1; hit_mask = 4'b1111;
    repeat (99) cyc();
    chk("sat99_ones", int'(score_ones), 9);
    chk("sat99_tens", int'(score_tens), 9);
    cyc();
    chk("sat100_ones", int'(score_ones), 9);
    chk("sat100_tens", int'(score_tens), 9);
    chk("sat100_ack", int'(hit_ack), 1);
    idle_in();

    reset = 1; cyc();
    idle_in(); start = 1; cyc();
    start = 0; tick = 1;
    for (int c = 0; c < 600; c++) begin
      cyc();
      if (state == 2'b10) break;
    end
    chk("esc_state", int'(state), 2);
    chk("esc_over", int'(game_over), 1);
    chk("esc_y0", dut_y(0), 450);

    hit_valid = 1; hit_mask = 4'b1111;
    repeat (10) cyc();
    chk("over_ack", int'(hit_ack), 0);
    chk("over_y0", dut_y(0), 450);
    chk("over_active", int'(ast_active), 15);

    idle_in(); start = 1; cyc();
    start = 0;
    chk("restart_state", int'(state), 1);
    chk("restart_y0", dut_y(0), -25);
    chk("restart_y3", dut_y(3), -175);
    chk("restart_over", int'(game_over), 0);

    tick = 1; repeat (5) cyc();
    reset = 1; start = 1; hit_valid = 1; hit_mask = 4'b1111; cyc();
    chk("midrst_state", int'(state), 0);
    chk("midrst_active", int'(ast_active), 0);
    chk("midrst_x0", dut_x(0), 0);
    chk("midrst_y0", dut_y(0), 0);
    chk("midrst_ack", int'(hit_ack), 0);
    idle_in(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
